hack_screen_pixel_fetch: RTL and testbench
==========================================

# hack_screen_pixel_fetch

Downstream stage of the 640x480 video timing generator. Fetches the 512x256 monochrome Hack screen (16-bit words, base 0x4000) from video memory over a request/acknowledge port, one display line ahead. Buffers up to two words and serialises them into the 1-bit RGB output, centred in the 640x480 active area. Also delays HSYNC/VSYNC to stay aligned with the registered pixel.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `X_OFFSET`, 64, first screen column in hpos; must be a multiple of 16
- `Y_OFFSET`, 112, first screen row in vpos; must be ≥1
- `BASE_ADDR`, 16'h4000, Hack SCREEN base word address
- `clk`  in  1  pixel clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `hpos`  in  10  pixel x from timing generator
- `vpos`  in  10  line y from timing generator
- `display_active`  in  1  high during active pixels
- `hsync_in`, `vsync_in`  in  1 each  syncs from timing generator
- `rd_req`  out  1  word read request
- `rd_addr`  out  16  word address; stable while `rd_req` high
- `rd_ack`  in  1  one-cycle pulse; `rd_data` valid in the same cycle
- `rd_data`  in  16  screen word
- `rgb`  out  1  registered pixel
- `hsync_out`, `vsync_out`  out  1 each  syncs delayed by 1 cycle
- `underrun`  out  1  sticky error flag

## Operation
- **Screen window:** x = hpos−X_OFFSET in [0,511] and y = vpos−Y_OFFSET in [0,255].
- **Line start:** happens at hpos==H_ACTIVE (first hblank pixel) when next line vpos+1 (11-bit compare) is in the window with row r = vpos+1−Y_OFFSET. At line start:
  - FIFO is flushed.
  - Issued-word counter `wcnt` (6 bit) is cleared.
  - Row address = BASE_ADDR + r*32.
- **Fetch FSM:**
  - IDLE → REQ when `wcnt`<32 and FIFO occupancy plus outstanding requests is <2.
  - REQ holds `rd_req`=1 and `rd_addr`=row+wcnt until `rd_ack`.
  - On `rd_ack`: push `rd_data`, increment `wcnt`, return to IDLE.
  - Back-to-back issue is allowed the cycle after ack.
- **Line start while in REQ:**
  - The handshake completes normally.
  - A `drop` flag discards the returned word; it is not pushed and `wcnt` is not advanced.
  - The FSM then restarts at word 0 of the new row.
- **FIFO:** 2 entries.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Push is never attempted when full, because the FSM gates issue.
- **Shifter:**
  - When `display_active` and in window with x[3:0]==0, pop one word into a 16-bit shift register.
  - The current pixel is bit 0 of the popped word; subsequent pixels shift right (LSB = leftmost pixel, Hack convention).
- **Underrun:** popping while the FIFO is empty sets `underrun`=1 (sticky until reset) and loads 16'h0000.
- **Pixel value:**
  - In window, `rgb` = ~pixel bit (Hack 1 = black).
  - Outside window or when `display_active`=0, `rgb`=0.

## Timing
- Reset values:
  - `rd_req`=0, `rd_addr`=0
  - `rgb`=0, `hsync_out`=1, `vsync_out`=1
  - `underrun`=0
  - FIFO empty, FSM IDLE, `wcnt`=32 (no fetch until first line start)
- **Latency:** `rgb`, `hsync_out` and `vsync_out` are registered, 1 cycle after their `hpos`/`vpos`/`hsync_in`/`vsync_in` inputs.
- **Memory rate:** memory must sustain one word per 16 cycles after the first.
- **Row prefetch:** the first two words of a row are prefetched during hblank (≥160 cycles).
- **Reset mid-transaction:** `rd_req` drops asynchronously; memory side must abandon the read.
- **Frame wrap:** Y_OFFSET≥1 guarantees the top row is fetched during line Y_OFFSET−1, never across vpos wrap.

## Structure
- Package `hack_video_pkg` holds:
  - SCREEN_BASE (16'h4000)
  - SCREEN_W=512, SCREEN_H=256
  - WORDS_PER_ROW=32
  - FSM state enum {IDLE, REQ}
- Sub-module `hack_video_word_fifo`: 2-entry, 16-bit synchronous FIFO with push, pop, flush, full, empty and count outputs.

## Test plan
- Reset released, memory acks after 3 cycles with data = address low bits → at line 112 the first `rd_addr`=0x4000 is issued at hpos=640 of line 111, and `rd_addr`=0x401F is the last address of that row.
- Word 16'h0001 at column 0, row 0 → `rgb`=0 one cycle after hpos=64, vpos=112 and `rgb`=1 for hpos 65..79; `rgb`=0 at hpos 63 and 576.
- Memory ack delayed 40 cycles → `underrun`=1 by row 0 word 3, stays 1; affected pixels `rgb`=1 (white).
- Line start asserted while REQ is outstanding with ack at +5 cycles → that word is not pushed; next `rd_addr` is the new row base (e.g. 0x4020).
- `hsync_in` pulse at hpos 656..751 → `hsync_out` is the same pulse shifted by exactly 1 cycle; `vsync_out` likewise.
- `reset_n` low mid-line with `rd_req`=1 → `rd_req`, `rgb`, `underrun` go 0 immediately (no clock edge); the next frame fetches normally.

Source files
------------

// File: rtl/hack_video_pkg.sv
// Shared constants and types for the Hack screen fetch path.
package hack_video_pkg;

  localparam logic [15:0] SCREEN_BASE   = 16'h4000;
  localparam int          SCREEN_W      = 512;
  localparam int          SCREEN_H      = 256;
  localparam int          WORDS_PER_ROW = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  // Word address of the first word of screen row r (32 words per row).
  function automatic logic [15:0] row_base(input logic [15:0] base, input logic [7:0] r);
    return base + {3'b000, r, 5'b00000};
  endfunction

endpackage

// File: rtl/hack_video_word_fifo.sv
// Two-entry 16-bit word FIFO between the memory port and the pixel shifter.
module hack_video_word_fifo (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  logic [15:0] wdata_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [15:0] rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [1:0]  count_o
);

  logic [15:0] mem_q [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  cnt_q;
  logic        do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Overflow/underflow requests are ignored so the pointers never corrupt.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; flush discards everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hack_screen_pixel_fetch.sv
// Fetches the 512x256 Hack screen one line ahead and serialises it,
// centred in the 640x480 active area, with syncs delayed to match.
module hack_screen_pixel_fetch
  import hack_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned X_OFFSET  = 64,   // multiple of 16
  parameter int unsigned Y_OFFSET  = 112,  // at least 1
  parameter logic [15:0] BASE_ADDR = SCREEN_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic        rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        underrun
);

  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] XO = 11'(X_OFFSET);
  localparam logic [10:0] XE = 11'(X_OFFSET + SCREEN_W);
  localparam logic [10:0] YO = 11'(Y_OFFSET);
  localparam logic [10:0] YE = 11'(Y_OFFSET + SCREEN_H);

  // ---------------------------------------------------------------------
  // Window decode and line-start detection
  // ---------------------------------------------------------------------
  logic [10:0] h11, v11, vnext;
  logic [7:0]  rnext;
  logic        in_win, next_in, line_start;
  logic [15:0] new_row;

  assign h11   = {1'b0, hpos};
  assign v11   = {1'b0, vpos};
  assign vnext = v11 + 11'd1;     // 11 bits so line 1023+1 cannot alias
  assign rnext = vpos[7:0] + 8'd1 - 8'(Y_OFFSET);

  assign in_win     = (h11 >= XO) && (h11 < XE) && (v11 >= YO) && (v11 < YE);
  assign next_in    = (vnext >= YO) && (vnext < YE) && (vnext < VA);
  assign line_start = (h11 == HA) && next_in;
  assign new_row    = row_base(BASE_ADDR, rnext);

  // ---------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------
  fetch_state_e state_q;
  logic         rd_req_q, drop_q;
  logic [15:0]  rd_addr_q, row_q;
  logic [5:0]   wcnt_q;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0] fifo_rdata;
  logic [1:0]  fifo_count;
  logic        pop_slot;

  // A word returned for a superseded row, or landing on the line-start
  // cycle itself, belongs to the old row and is thrown away.
  assign fifo_push = rd_ack && (state_q == REQ) && !drop_q && !line_start && !fifo_full;

  // X_OFFSET is a multiple of 16, so hpos[3:0] equals the screen x[3:0].
  assign pop_slot = display_active && in_win && (hpos[3:0] == 4'd0);
  assign fifo_pop = pop_slot;

  hack_video_word_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .wdata_i (rd_data),
    .pop_i   (fifo_pop),
    .flush_i (line_start),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------
  // One read in flight; every line start restarts the row at word 0, and a
  // read still open at that moment is finished but marked for dropping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      row_q     <= BASE_ADDR;
      wcnt_q    <= 6'(WORDS_PER_ROW);   // nothing fetched before first line start
      drop_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (line_start) begin
            // FIFO is being flushed, so word 0 of the new row can go out now.
            row_q     <= new_row;
            wcnt_q    <= '0;
            rd_addr_q <= new_row;
            rd_req_q  <= 1'b1;
            state_q   <= REQ;
          end else if ((wcnt_q < 6'(WORDS_PER_ROW)) && (fifo_count < 2'd2)) begin
            rd_addr_q <= row_q + 16'(wcnt_q);
            rd_req_q  <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (rd_ack) begin
            rd_req_q <= 1'b0;
            state_q  <= IDLE;
            drop_q   <= 1'b0;
            if (line_start) begin
              row_q  <= new_row;
              wcnt_q <= '0;
            end else if (!drop_q) begin
              wcnt_q <= wcnt_q + 6'd1;
            end
          end else if (line_start) begin
            row_q  <= new_row;
            wcnt_q <= '0;
            drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;

  // ---------------------------------------------------------------------
  // Pixel shifter and output registers
  // ---------------------------------------------------------------------
  logic [15:0] shreg_q;
  logic [15:0] pix_word;
  logic        cur_pix;
  logic        rgb_q, hs_q, vs_q, underrun_q;

  // An empty FIFO at a word boundary yields an all-zero (white) word.
  assign pix_word = fifo_empty ? 16'h0000 : fifo_rdata;
  assign cur_pix  = pop_slot ? pix_word[0] : shreg_q[0];

  // LSB is the leftmost pixel; hold the remaining 15 bits and shift right.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q    <= '0;
      rgb_q      <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      shreg_q <= pop_slot ? {1'b0, pix_word[15:1]} : {1'b0, shreg_q[15:1]};
      rgb_q   <= display_active && in_win && !cur_pix;   // Hack 1 = black
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
      if (pop_slot && fifo_empty) underrun_q <= 1'b1;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_hack_screen_pixel_fetch.sv
// Drives a shortened 800x525 raster around the screen window, serves reads
// from a random video memory and compares every output cycle with a
// queue-based reference of the fetch/display rules.
module tb_hack_screen_pixel_fetch;

  localparam int HA = 640, HT = 800, XO = 64, YO = 112;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hpos, vpos;
  logic        display_active, hsync_in, vsync_in;
  logic        rd_req, rd_ack;
  logic [15:0] rd_addr, rd_data;
  logic        rgb, hsync_out, vsync_out, underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hack_screen_pixel_fetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hpos           (hpos),
    .vpos           (vpos),
    .display_active (display_active),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data),
    .rgb            (rgb),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .underrun       (underrun)
  );

  logic [15:0] vmem [0:8191];

  // memory responder
  int          lat;
  bit          busy, stale, short_ack, drop_seen, want_drop;
  int          mcnt;
  logic [15:0] maddr, drop_addr;
  // reference model
  logic [15:0] q[$];
  logic [15:0] cur_w;
  bit          m_under;
  int          exp_row, exp_idx;
  int          first_h, first_v;
  logic [15:0] first_addr, last_row0;

  function automatic bit win(int h, int v);
    return (h >= XO) && (h < XO + 512) && (v >= YO) && (v < YO + 256);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur_w = '0; m_under = 0; busy = 0; stale = 0; mcnt = 0;
    exp_row = -1; exp_idx = 0; first_h = -1; first_v = -1;
    first_addr = '0; last_row0 = '0; short_ack = 0; want_drop = 0;
  endtask

  // One pixel clock: drive raster + memory, update the model, check outputs.
  task automatic step();
    int h, v, x;
    bit ackd, ls, act, exp_rgb;
    h = int'(hpos); v = int'(vpos);
    act = (h < HA) && (v < 480);
    display_active = act;
    hsync_in = !(h >= 656 && h < 752);
    vsync_in = !(v == 114);
    ackd = busy && (mcnt == 0);
    rd_ack  = ackd;
    rd_data = ackd ? vmem[maddr[12:0]] : 16'($urandom);

    exp_rgb = 1'b0;
    if (act && win(h, v)) begin
      x = h - XO;
      if (x % 16 == 0) begin
        if (q.size() == 0) begin cur_w = 16'h0000; m_under = 1; end
        else cur_w = q.pop_front();
      end
      exp_rgb = !cur_w[x % 16];
    end
    if (ackd && !stale) begin q.push_back(rd_data); exp_idx++; end
    ls = (h == HA) && win(XO, v + 1);
    if (ls) begin
      q.delete();
      exp_row = v + 1 - YO;
      exp_idx = 0;
      if (busy && !ackd) stale = 1;
      if (short_ack) begin
        drop_seen = busy && !ackd;
        if (drop_seen) mcnt = 5;
        short_ack = 0; lat = 3; want_drop = 1;
      end
    end

    @(posedge clk); #1;
    chk("rgb", rgb, exp_rgb);
    chk("hsync_out", hsync_out, hsync_in);
    chk("vsync_out", vsync_out, vsync_in);
    chk("underrun", underrun, m_under);
    if (v == 112 && (h == 63 || h == 64 || h == 576)) chk("px_edge", rgb, 0);
    if (v == 112 && h >= 65 && h <= 79) chk("px_word0", rgb, 1);

    if (ackd) begin
      busy = 0;
      chk("req_release", rd_req, 0);
    end else if (busy) begin
      chk("req_hold", rd_req, 1);
      chk("addr_hold", rd_addr, maddr);
      mcnt--;
    end else if (rd_req === 1'b1) begin
      chk("issue_allowed", (exp_row >= 0) && (exp_idx < 32), 1);
      chk("issue_addr", rd_addr, 16'h4000 + exp_row * 32 + exp_idx);
      if (first_h < 0) begin first_h = h; first_v = v; first_addr = rd_addr; end
      if (exp_row == 0) last_row0 = rd_addr;
      if (want_drop) begin drop_addr = rd_addr; want_drop = 0; end
      busy = 1; stale = 0; mcnt = lat - 1; maddr = rd_addr;
    end

    if (h + 1 == HT) begin hpos = '0; vpos = 10'(v + 1); end
    else hpos = 10'(h + 1);
  endtask

  task automatic run_lines(int n);
    repeat (n * HT) step();
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 8192; i++) vmem[i] = 16'($urandom);
    vmem[0] = 16'h0001;
    model_reset();
    lat = 3; drop_seen = 0; drop_addr = '0;
    reset_n = 1'b0; hpos = '0; vpos = 10'd110;
    display_active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    rd_ack = 1'b0; rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync_out, 1);
    chk("rst_vsync", vsync_out, 1);
    chk("rst_underrun", underrun, 0);
    reset_n = 1'b1;

    // lines 110..113, fast memory: row 0 and 1 displayed cleanly
    run_lines(4);
    chk("first_issue_h", first_h, 640);
    chk("first_issue_v", first_v, 111);
    chk("first_issue_addr", first_addr, 16'h4000);
    chk("row0_last_addr", last_row0, 16'h401F);
    chk("no_underrun_fast", underrun, 0);

    // line 114, 40-cycle memory: starves the shifter
    lat = 40;
    run_lines(1);
    chk("underrun_slow", underrun, 1);

    // line 115: read stalls, line start hits it, ack arrives 5 cycles later
    lat = 1000; short_ack = 1;
    run_lines(1);
    chk("drop_armed", drop_seen, 1);
    chk("drop_next_addr", drop_addr, 16'h4080);
    run_lines(2);
    chk("underrun_sticky", underrun, 1);

    // reset while a read is open
    lat = 1000;
    guard = 0;
    while (!busy && guard < HT) begin step(); guard++; end
    chk("mid_req_seen", rd_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_req", rd_req, 0);
    chk("async_rgb", rgb, 0);
    chk("async_underrun", underrun, 0);
    chk("async_hsync", hsync_out, 1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    lat = 3; hpos = '0; vpos = 10'd110;
    reset_n = 1'b1;
    run_lines(4);
    chk("re_first_h", first_h, 640);
    chk("re_first_v", first_v, 111);
    chk("re_first_addr", first_addr, 16'h4000);
    chk("re_no_underrun", underrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
